frame_capture_tx: RTL and testbench
===================================

FRAME_CAPTURE_TX -- requirements
Module: frame_capture_tx

Interface
- REQ-001 SHALL have parameter PIC_W, default 80, meaning the capture window width in pixels.
- REQ-002 SHALL have parameter PIC_H, default 80, meaning the capture window height in lines.
- REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the first header byte of every line packet.
- REQ-004 SHALL have port hdmi_clk, input, 1, the sole clock; all logic is on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low, sampled on hdmi_clk.
- REQ-006 SHALL have port cap_req, input, 1, a single-cycle request to capture one frame.
- REQ-007 SHALL have port de, input, 1, the video data-enable.
- REQ-008 SHALL have port pic_x, input, 12, the current pixel column.
- REQ-009 SHALL have port pic_y, input, 12, the current pixel line.
- REQ-010 SHALL have port pix_data, input, 16, the current RGB565 pixel, valid when de=1.
- REQ-011 SHALL have port tx_data, output, 8, the outgoing byte.
- REQ-012 SHALL have port tx_valid, output, 1, asserted while tx_data holds a valid byte.
- REQ-013 SHALL have port tx_ready, input, 1, the downstream accept signal.
- REQ-014 SHALL have port tx_last, output, 1, marking the final byte of a line packet.
- REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
- REQ-016 SHALL have port done, output, 1, a one-cycle pulse after the final byte of the frame is accepted.

Function
- REQ-017 SHALL use states IDLE, ARM, CAPTURE, SEND_HDR, SEND_PIX and DONE.
- REQ-018 SHALL move IDLE->ARM on cap_req=1; cap_req in any other state SHALL be ignored, not queued.
- REQ-019 SHALL treat "frame start" as de=1 with pic_x=0 and pic_y=0.
- REQ-020 SHALL, in ARM, on frame start, write pix_data to buffer address 0 in the same cycle and move to CAPTURE.
- REQ-021 SHALL hold an internal PIC_W*PIC_H x 16 buffer; in CAPTURE, every cycle with de=1, pic_x<PIC_W and pic_y<PIC_H SHALL write pix_data at address pic_y*PIC_W+pic_x.
- REQ-022 SHALL ignore pixels outside the window and cycles with de=0.
- REQ-023 SHALL leave CAPTURE for SEND_HDR once the pixel at (PIC_W-1, PIC_H-1) has been written.
- REQ-024 SHALL, on a frame start received while in CAPTURE, write address 0 and keep capturing; the capture SHALL NOT abort.
- REQ-025 SHALL emit one packet per line L = 0..PIC_H-1, in ascending order.
- REQ-026 SHALL make each packet: SYNC_BYTE, then L[7:0], then for x = 0..PIC_W-1 pixel[15:8] followed by pixel[7:0], for a total of 2+2*PIC_W bytes (162 at defaults).
- REQ-027 SHALL assert tx_last only on the final pixel low byte of each packet.
- REQ-028 SHALL transfer a byte only in a cycle where tx_valid=1 and tx_ready=1.
- REQ-029 SHALL, while tx_valid=1 and tx_ready=0, hold tx_data and tx_last stable and keep tx_valid=1.
- REQ-030 SHALL support one transfer per cycle when tx_ready is held at 1.
  - The buffer read latency (1 cycle) SHALL be hidden by prefetch or a skid register.
  - At most a 2-cycle tx_valid bubble is allowed at the start of each packet.
- REQ-031 SHALL, after the final byte of line PIC_H-1 is accepted, enter DONE for one cycle with done=1, then return to IDLE.
- REQ-032 SHALL use line and pixel counters with widths sized by $clog2 of PIC_H and PIC_W; the buffer address SHALL be sized by $clog2(PIC_W*PIC_H).
- REQ-033 SHALL NOT advance the video inputs' effect during SEND_*, and pixel input SHALL have no effect on the buffer in those states.

Reset
- REQ-034 SHALL, on rst_n=0 at a clock edge in any state including mid-capture or mid-packet, enter IDLE.
- REQ-035 SHALL, on reset, set tx_valid=0, tx_last=0, tx_data=8'h00, busy=0, done=0, and clear all counters.
- REQ-036 SHALL NOT require buffer contents to be cleared by reset.
- REQ-037 SHALL ignore cap_req while rst_n=0.

Verification
- REQ-038 Full frame, tx_ready=1: pix_data = {pic_y[7:0], pic_x[7:0]}, pulse cap_req -> 80 packets of 162 bytes each; packet L is A5, L, then for each x the bytes L, x; tx_last appears 80 times; done pulses once.
- REQ-039 Backpressure: toggle tx_ready pseudo-randomly -> identical byte sequence to REQ-038, and tx_data/tx_last never change while tx_valid=1 and tx_ready=0.
- REQ-040 Arm timing: cap_req mid-frame at (30,40) -> no write until the next (0,0); the captured data equals the next frame; busy=1 from the cycle after cap_req.
- REQ-041 Ignored request: pulse cap_req during SEND_PIX -> exactly one frame is sent; state is IDLE after done.
- REQ-042 Reset mid-packet: rst_n=0 for 1 cycle at byte 50 of line 3 -> the next cycle shows tx_valid=0, busy=0; a new cap_req yields a complete, correct frame.
- REQ-043 Out-of-window: pixels with pic_x>=80 or de=0 carry FFFF -> no FFFF bytes appear in the payload.

Source files
------------

// File: rtl/frame_capture_tx.sv
// Captures one PIC_W x PIC_H video window into on-chip RAM, then streams it
// line by line as byte packets: SYNC_BYTE, line number, then pixels high byte first.
module frame_capture_tx #(
  parameter int         PIC_W     = 80,
  parameter int         PIC_H     = 80,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic        cap_req,
  input  logic        de,
  input  logic [11:0] pic_x,
  input  logic [11:0] pic_y,
  input  logic [15:0] pix_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  localparam int NPIX   = PIC_W * PIC_H;
  localparam int ADDR_W = (NPIX  > 1) ? $clog2(NPIX)  : 1;
  localparam int XW     = (PIC_W > 1) ? $clog2(PIC_W) : 1;
  localparam int YW     = (PIC_H > 1) ? $clog2(PIC_H) : 1;

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, SEND_HDR, SEND_PIX, DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]       mem [NPIX];
  logic [15:0]       rd_data_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] wr_addr;
  logic [XW-1:0]     px_cnt_reg;
  logic [YW-1:0]     line_cnt_reg;
  logic              half_reg;
  logic              hdr_idx_reg;
  logic              tail_reg;
  logic [7:0]        lo_byte_reg;
  logic [7:0]        tx_data_reg;
  logic              tx_valid_reg;
  logic              tx_last_reg;

  logic frame_start, in_win, wr_en, cap_last_pix;
  logic can_load, last_px, last_line, pix_step, rd_en;

  assign frame_start  = de && (pic_x == 12'd0) && (pic_y == 12'd0);
  assign in_win       = de && (pic_x < 12'(PIC_W)) && (pic_y < 12'(PIC_H));
  assign wr_en        = ((state_reg == ARM) && frame_start) || ((state_reg == CAPTURE) && in_win);
  assign wr_addr      = ADDR_W'(32'(pic_y) * 32'(PIC_W) + 32'(pic_x));
  assign cap_last_pix = (state_reg == CAPTURE) && de &&
                        (pic_x == 12'(PIC_W - 1)) && (pic_y == 12'(PIC_H - 1));

  assign can_load  = !tx_valid_reg || tx_ready;
  assign last_px   = (px_cnt_reg == XW'(PIC_W - 1));
  assign last_line = (line_cnt_reg == YW'(PIC_H - 1));
  assign pix_step  = (state_reg == SEND_PIX) && can_load && !tail_reg;
  // Readout is strictly sequential, so one running pointer replaces y*W+x.
  // Each high-byte load prefetches the next pixel; the first one is read on leaving CAPTURE.
  assign rd_en     = cap_last_pix || (pix_step && !half_reg && !(last_px && last_line));

  always_ff @(posedge hdmi_clk) begin
    if (wr_en) mem[wr_addr] <= pix_data;
    if (rd_en) rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (cap_req) state_next = ARM;
      ARM:      if (frame_start) state_next = CAPTURE;
      CAPTURE:  if (cap_last_pix) state_next = SEND_HDR;
      SEND_HDR: if (can_load && hdr_idx_reg) state_next = SEND_PIX;
      SEND_PIX: begin
        if (tail_reg) begin
          if (tx_valid_reg && tx_ready) state_next = DONE;
        end else if (pix_step && half_reg && last_px && !last_line) begin
          state_next = SEND_HDR;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      tx_last_reg  <= 1'b0;
      lo_byte_reg  <= 8'h00;
      rd_ptr_reg   <= '0;
      px_cnt_reg   <= '0;
      line_cnt_reg <= '0;
      half_reg     <= 1'b0;
      hdr_idx_reg  <= 1'b0;
      tail_reg     <= 1'b0;
    end else begin
      if (tx_valid_reg && tx_ready) begin
        tx_valid_reg <= 1'b0;
        tx_last_reg  <= 1'b0;
      end
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          rd_ptr_reg   <= '0;
          px_cnt_reg   <= '0;
          line_cnt_reg <= '0;
          half_reg     <= 1'b0;
          hdr_idx_reg  <= 1'b0;
          tail_reg     <= 1'b0;
        end
        SEND_HDR: if (can_load) begin
          tx_valid_reg <= 1'b1;
          tx_last_reg  <= 1'b0;
          tx_data_reg  <= hdr_idx_reg ? 8'(line_cnt_reg) : SYNC_BYTE;
          hdr_idx_reg  <= ~hdr_idx_reg;
        end
        SEND_PIX: if (pix_step) begin
          tx_valid_reg <= 1'b1;
          half_reg     <= ~half_reg;
          if (!half_reg) begin
            tx_data_reg <= rd_data_reg[15:8];
            lo_byte_reg <= rd_data_reg[7:0];
            tx_last_reg <= 1'b0;
          end else begin
            tx_data_reg <= lo_byte_reg;
            tx_last_reg <= last_px;
            if (last_px) begin
              px_cnt_reg <= '0;
              // After the last line, hold here until the final byte is accepted.
              if (last_line) tail_reg <= 1'b1;
              else           line_cnt_reg <= line_cnt_reg + 1'b1;
            end else begin
              px_cnt_reg <= px_cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign tx_last  = tx_last_reg;

endmodule

// File: tb/tb_frame_capture_tx.sv
// Bench for frame_capture_tx: free-running video source, random tx_ready,
// expected packet bytes queued at each capture request and checked on every transfer.
module tb_frame_capture_tx;

  localparam int W     = 80;
  localparam int H     = 80;
  localparam int H_TOT = 83;
  localparam int V_TOT = 81;
  localparam int PKT   = 2 + 2 * W;

  logic        hdmi_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        cap_req  = 1'b0;
  logic        de       = 1'b0;
  logic        tx_ready = 1'b1;
  logic [11:0] pic_x    = 12'd0;
  logic [11:0] pic_y    = 12'd0;
  logic [15:0] pix_data = 16'hFFFF;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, done;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  int          xfer_cnt   = 0;
  int          last_cnt   = 0;
  int          done_cnt   = 0;
  int          ready_pct  = 100;
  logic [15:0] pat_xor    = 16'h0000;

  frame_capture_tx #(.PIC_W(W), .PIC_H(H), .SYNC_BYTE(8'hA5)) dut (
    .hdmi_clk (hdmi_clk),
    .rst_n    (rst_n),
    .cap_req  (cap_req),
    .de       (de),
    .pic_x    (pic_x),
    .pic_y    (pic_y),
    .pix_data (pix_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  // Video source: 80x80 window, columns 80..81 are active but out of window,
  // column 82 and line 80 are blanking; everything outside the window carries FFFF.
  initial begin
    int vx, vy;
    vx = 0;
    vy = 0;
    forever begin
      @(posedge hdmi_clk);
      #1;
      if (vx == H_TOT - 1) begin
        vx = 0;
        vy = (vy == V_TOT - 1) ? 0 : vy + 1;
      end else begin
        vx++;
      end
      if (vx == 0 && vy == 0) pat_xor = 16'h0000;
      de       = (vx < W + 2) && (vy < H);
      pix_data = (vx < W && vy < H) ? ({vy[7:0], vx[7:0]} ^ pat_xor) : 16'hFFFF;
      pic_x    = 12'(vx);
      pic_y    = 12'(vy);
    end
  end

  initial begin
    forever begin
      @(posedge hdmi_clk);
      #1;
      tx_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Scoreboard monitor: pops one expected byte per accepted transfer.
  initial begin
    exp_t       e;
    logic       hold_pend;
    logic [7:0] hold_data;
    logic       hold_last;
    hold_pend = 1'b0;
    hold_data = 8'h00;
    hold_last = 1'b0;
    forever begin
      @(negedge hdmi_clk);
      if (rst_n !== 1'b1) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          assert_cnt++;
          if (tx_valid !== 1'b1 || tx_data !== hold_data || tx_last !== hold_last) begin
            fail_cnt++;
            $display("FAIL hold_stable: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                     tx_valid, tx_data, tx_last, hold_data, hold_last);
          end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
          assert_cnt++;
          if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL unexpected_byte: got data=%h last=%0b, required no transfer", tx_data, tx_last);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || tx_last !== e.last) begin
              fail_cnt++;
              $display("FAIL byte_%0d: got data=%h last=%0b, required data=%h last=%0b",
                       xfer_cnt, tx_data, tx_last, e.data, e.last);
            end
          end
          xfer_cnt++;
          if (tx_last === 1'b1) begin
            last_cnt++;
            $display("packet %0d received, %0d bytes total at t=%0t", last_cnt, xfer_cnt, $time);
          end
        end
        hold_pend = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
        hold_data = tx_data;
        hold_last = tx_last;
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  task automatic push_frame();
    for (int l = 0; l < H; l++) begin
      exp_q.push_back({8'hA5, 1'b0});
      exp_q.push_back({l[7:0], 1'b0});
      for (int x = 0; x < W; x++) begin
        exp_q.push_back({l[7:0], 1'b0});
        exp_q.push_back({x[7:0], (x == W - 1)});
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    cap_req = 1'b1;
    repeat (3) @(negedge hdmi_clk);
    assert_cnt++;
    if (tx_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_tx_valid: got %0b, required 0", tx_valid); end
    assert_cnt++;
    if (tx_last !== 1'b0) begin fail_cnt++; $display("FAIL rst_tx_last: got %0b, required 0", tx_last); end
    assert_cnt++;
    if (tx_data !== 8'h00) begin fail_cnt++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    assert_cnt++;
    if (done !== 1'b0) begin fail_cnt++; $display("FAIL rst_done: got %0b, required 0", done); end
    cap_req = 1'b0;
    rst_n   = 1'b1;
    repeat (4) @(negedge hdmi_clk);
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_cap_ignored: got busy=%0b, required 0", busy); end
    assert_cnt++;
    if (tx_valid !== 1'b0) begin fail_cnt++; $display("FAIL post_rst_tx_valid: got %0b, required 0", tx_valid); end
  endtask

  // Request arrives at (30,40) of a frame whose remaining pixels are scrambled;
  // only the following clean frame may end up in the packets. Also ignores a
  // second request made while pixels are being sent.
  task automatic test_arm_backpressure();
    int c, d0, l0, x0;
    ready_pct = 80;
    c = 0;
    do begin
      @(posedge hdmi_clk);
      #2;
      c++;
    end while (!(pic_x == 12'd30 && pic_y == 12'd40) && c < 20000);
    assert_cnt++;
    if (c >= 20000) begin fail_cnt++; $display("FAIL arm_wait_pos: got timeout, required pixel (30,40)"); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL arm_busy_before: got %0b, required 0", busy); end
    d0 = done_cnt;
    l0 = last_cnt;
    x0 = xfer_cnt;
    cap_req = 1'b1;
    pat_xor = 16'h5A5A;
    push_frame();
    @(posedge hdmi_clk);
    #2;
    cap_req = 1'b0;
    assert_cnt++;
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL arm_busy_after: got %0b, required 1", busy); end
    c = 0;
    while (xfer_cnt - x0 < 1000 && c < 60000) begin
      @(posedge hdmi_clk);
      #2;
      c++;
    end
    assert_cnt++;
    if (c >= 60000) begin fail_cnt++; $display("FAIL ign_wait_bytes: got %0d bytes, required 1000", xfer_cnt - x0); end
    cap_req = 1'b1;
    @(posedge hdmi_clk);
    #2;
    cap_req = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 60000) begin
      @(negedge hdmi_clk);
      c++;
    end
    assert_cnt++;
    if (c >= 60000) begin fail_cnt++; $display("FAIL bp_done_timeout: got no done, required done pulse"); end
    @(negedge hdmi_clk);
    assert_cnt++;
    if (done !== 1'b0) begin fail_cnt++; $display("FAIL bp_done_width: got done=%0b, required 0", done); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL bp_idle_after_done: got busy=%0b, required 0", busy); end
    repeat (300) @(negedge hdmi_clk);
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL ign_req_queued: got busy=%0b, required 0", busy); end
    assert_cnt++;
    if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0); end
    assert_cnt++;
    if (last_cnt - l0 != H) begin fail_cnt++; $display("FAIL bp_last_count: got %0d, required %0d", last_cnt - l0, H); end
    assert_cnt++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL bp_leftover: got %0d bytes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    int c, x0;
    ready_pct = 100;
    x0 = xfer_cnt;
    cap_req = 1'b1;
    push_frame();
    @(posedge hdmi_clk);
    #2;
    cap_req = 1'b0;
    c = 0;
    while (xfer_cnt - x0 < 3 * PKT + 50 && c < 40000) begin
      @(negedge hdmi_clk);
      c++;
    end
    assert_cnt++;
    if (c >= 40000) begin fail_cnt++; $display("FAIL mid_wait_bytes: got %0d bytes, required %0d", xfer_cnt - x0, 3 * PKT + 50); end
    rst_n = 1'b0;
    @(negedge hdmi_clk);
    assert_cnt++;
    if (tx_valid !== 1'b0) begin fail_cnt++; $display("FAIL mid_rst_tx_valid: got %0b, required 0", tx_valid); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_rst_busy: got %0b, required 0", busy); end
    assert_cnt++;
    if (tx_data !== 8'h00 || tx_last !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_rst_tx_regs: got data=%h last=%0b, required data=00 last=0", tx_data, tx_last);
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge hdmi_clk);
  endtask

  task automatic test_full_frame();
    int c, d0, l0, x0, span;
    bit started;
    ready_pct = 100;
    d0 = done_cnt;
    l0 = last_cnt;
    x0 = xfer_cnt;
    cap_req = 1'b1;
    push_frame();
    @(posedge hdmi_clk);
    #2;
    cap_req = 1'b0;
    c = 0;
    span = 0;
    started = 1'b0;
    while (done !== 1'b1 && c < 60000) begin
      @(negedge hdmi_clk);
      if (tx_valid === 1'b1) started = 1'b1;
      if (started) span++;
      c++;
    end
    assert_cnt++;
    if (c >= 60000) begin fail_cnt++; $display("FAIL full_done_timeout: got no done, required done pulse"); end
    assert_cnt++;
    if (span > H * PKT + 2 * H + 2) begin
      fail_cnt++;
      $display("FAIL full_throughput: got %0d cycles, required at most %0d", span, H * PKT + 2 * H + 2);
    end
    @(negedge hdmi_clk);
    assert_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL full_idle_after_done: got busy=%0b done=%0b, required 0 0", busy, done);
    end
    assert_cnt++;
    if (xfer_cnt - x0 != H * PKT) begin fail_cnt++; $display("FAIL full_byte_count: got %0d, required %0d", xfer_cnt - x0, H * PKT); end
    assert_cnt++;
    if (last_cnt - l0 != H) begin fail_cnt++; $display("FAIL full_last_count: got %0d, required %0d", last_cnt - l0, H); end
    assert_cnt++;
    if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL full_done_count: got %0d, required 1", done_cnt - d0); end
    assert_cnt++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL full_leftover: got %0d bytes missing, required 0", exp_q.size()); end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arm_backpressure();
    test_reset_mid_packet();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
